// File: rtl/face_pkg.sv
// Shared definitions for the skin-colour face detector: register map, ctrl bits,
// controller state encoding and default Cb/Cr window.
package face_pkg;

   localparam logic [2:0] ADDR_CB_LO = 3'd0;
   localparam logic [2:0] ADDR_CB_HI = 3'd1;
   localparam logic [2:0] ADDR_CR_LO = 3'd2;
   localparam logic [2:0] ADDR_CR_HI = 3'd3;
   localparam logic [2:0] ADDR_CTRL  = 3'd4;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_COMMIT_BIT = 1;

   localparam logic [7:0] CB_LO_DEF = 8'd77;
   localparam logic [7:0] CB_HI_DEF = 8'd127;
   localparam logic [7:0] CR_LO_DEF = 8'd133;
   localparam logic [7:0] CR_HI_DEF = 8'd173;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_DONE   = 2'd3
   } fsm_state_e;

   // A window is usable only when both lower bounds sit strictly below their upper bounds.
   function automatic logic window_ok(input logic [7:0] cb_lo, input logic [7:0] cb_hi,
                                      input logic [7:0] cr_lo, input logic [7:0] cr_hi);
      return (cb_lo < cb_hi) && (cr_lo < cr_hi);
   endfunction

endpackage

// File: rtl/face_det_ctrl_if.sv
// Host configuration bus of the face detector controller.
interface face_det_ctrl_if;
   logic       cfg_wr;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic       cfg_ack;
   logic       cfg_err;

   modport master (output cfg_wr, output cfg_addr, output cfg_wdata,
                   input cfg_ack, input cfg_err);
   modport slave  (input cfg_wr, input cfg_addr, input cfg_wdata,
                   output cfg_ack, output cfg_err);
endinterface

// File: rtl/face_thr_regs.sv
// Shadow/active Cb-Cr threshold bank: host writes land in shadow, a validated
// commit is copied to the active window at the next frame_start.
module face_thr_regs
   import face_pkg::*;
#(
   parameter logic [7:0] CB_LO_INIT = CB_LO_DEF,
   parameter logic [7:0] CB_HI_INIT = CB_HI_DEF,
   parameter logic [7:0] CR_LO_INIT = CR_LO_DEF,
   parameter logic [7:0] CR_HI_INIT = CR_HI_DEF
) (
   input  logic                  sclk,
   input  logic                  rst_n,
   face_det_ctrl_if.slave        cfg,
   input  logic                  frame_start,
   output logic [7:0]            cb_lower,
   output logic [7:0]            cb_upper,
   output logic [7:0]            cr_lower,
   output logic [7:0]            cr_upper,
   output logic                  enable
);

   logic [7:0] sh_cb_lo_r, sh_cb_hi_r, sh_cr_lo_r, sh_cr_hi_r;
   logic [7:0] act_cb_lo_r, act_cb_hi_r, act_cr_lo_r, act_cr_hi_r;
   logic       enable_r, commit_pend_r, cfg_ack_r, cfg_err_r;
   logic       commit_req_s, commit_ok_s, apply_s;

   assign commit_req_s = cfg.cfg_wr && (cfg.cfg_addr == ADDR_CTRL) && cfg.cfg_wdata[CTRL_COMMIT_BIT];
   assign commit_ok_s  = window_ok(sh_cb_lo_r, sh_cb_hi_r, sh_cr_lo_r, sh_cr_hi_r);
   // frame_start only ever sees the commit_pend already registered, never one arriving this cycle
   assign apply_s      = frame_start && commit_pend_r;

   // Host write decode into shadow and ctrl registers, plus the write acknowledge
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         sh_cb_lo_r <= CB_LO_INIT;
         sh_cb_hi_r <= CB_HI_INIT;
         sh_cr_lo_r <= CR_LO_INIT;
         sh_cr_hi_r <= CR_HI_INIT;
         enable_r   <= 1'b0;
         cfg_ack_r  <= 1'b0;
      end else begin
         cfg_ack_r <= cfg.cfg_wr;
         if (cfg.cfg_wr) begin
            case (cfg.cfg_addr)
               ADDR_CB_LO: sh_cb_lo_r <= cfg.cfg_wdata;
               ADDR_CB_HI: sh_cb_hi_r <= cfg.cfg_wdata;
               ADDR_CR_LO: sh_cr_lo_r <= cfg.cfg_wdata;
               ADDR_CR_HI: sh_cr_hi_r <= cfg.cfg_wdata;
               ADDR_CTRL:  enable_r   <= cfg.cfg_wdata[CTRL_EN_BIT];
               default:    enable_r   <= enable_r;
            endcase
         end
      end
   end

   // Commit validation and frame-boundary transfer of shadow into the active window
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         act_cb_lo_r   <= CB_LO_INIT;
         act_cb_hi_r   <= CB_HI_INIT;
         act_cr_lo_r   <= CR_LO_INIT;
         act_cr_hi_r   <= CR_HI_INIT;
         commit_pend_r <= 1'b0;
         cfg_err_r     <= 1'b0;
      end else begin
         if (apply_s) begin
            act_cb_lo_r <= sh_cb_lo_r;
            act_cb_hi_r <= sh_cb_hi_r;
            act_cr_lo_r <= sh_cr_lo_r;
            act_cr_hi_r <= sh_cr_hi_r;
         end
         if (commit_req_s && commit_ok_s) begin
            commit_pend_r <= 1'b1;
         end else if (apply_s) begin
            commit_pend_r <= 1'b0;
         end
         if (commit_req_s) begin
            cfg_err_r <= !commit_ok_s;
         end
      end
   end

   assign cb_lower    = act_cb_lo_r;
   assign cb_upper    = act_cb_hi_r;
   assign cr_lower    = act_cr_lo_r;
   assign cr_upper    = act_cr_hi_r;
   assign enable      = enable_r;
   assign cfg.cfg_ack = cfg_ack_r;
   assign cfg.cfg_err = cfg_err_r;

endmodule

// File: rtl/face_det_ctrl.sv
// Frame-level controller for the skin-colour face detector: sequences frames,
// counts detector beats and skin pixels, reports a per-frame skin total.
module face_det_ctrl
   import face_pkg::*;
#(
   parameter int         PIX_PER_FRAME = 307200,
   parameter int         CNT_W         = 19,
   parameter logic [7:0] CB_LO_INIT    = CB_LO_DEF,
   parameter logic [7:0] CB_HI_INIT    = CB_HI_DEF,
   parameter logic [7:0] CR_LO_INIT    = CR_LO_DEF,
   parameter logic [7:0] CR_HI_INIT    = CR_HI_DEF
) (
   input  logic             sclk,
   input  logic             rst_n,
   face_det_ctrl_if.slave   cfg,
   input  logic             frame_start,
   input  logic             face_flag,
   input  logic [7:0]       face_data,
   output logic [7:0]       cb_lower,
   output logic [7:0]       cb_upper,
   output logic [7:0]       cr_lower,
   output logic [7:0]       cr_upper,
   output logic             det_en,
   output logic             frame_done,
   output logic [CNT_W-1:0] skin_cnt,
   output logic             frame_err
);

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_FRAME - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   fsm_state_e       state_r, state_s;
   logic [CNT_W-1:0] pix_cnt_r, pix_cnt_s, skin_acc_r, skin_acc_s;
   logic [CNT_W-1:0] skin_bit_s, skin_total_s, skin_cnt_r;
   logic             enable_s, done_s, err_s;
   logic             det_en_r, frame_done_r, frame_err_r;
   logic             data_unused_s;

   face_thr_regs #(
      .CB_LO_INIT(CB_LO_INIT), .CB_HI_INIT(CB_HI_INIT),
      .CR_LO_INIT(CR_LO_INIT), .CR_HI_INIT(CR_HI_INIT)
   ) u_thr_regs (
      .sclk(sclk), .rst_n(rst_n), .cfg(cfg), .frame_start(frame_start),
      .cb_lower(cb_lower), .cb_upper(cb_upper), .cr_lower(cr_lower), .cr_upper(cr_upper),
      .enable(enable_s)
   );

   // Only the mask MSB carries the skin decision
   assign skin_bit_s    = {{(CNT_W-1){1'b0}}, face_data[7]};
   assign skin_total_s  = skin_acc_r + skin_bit_s;
   assign data_unused_s = ^face_data[6:0];

   // Next-state, counter update and event pulses
   always_comb begin
      state_s    = state_r;
      pix_cnt_s  = pix_cnt_r;
      skin_acc_s = skin_acc_r;
      done_s     = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable_s) state_s = ST_ARMED;
            else          state_s = ST_IDLE;
         end
         ST_ARMED: begin
            if (!enable_s) begin
               state_s = ST_IDLE;
            end else if (frame_start) begin
               state_s    = ST_ACTIVE;
               pix_cnt_s  = CNT_ZERO;
               skin_acc_s = CNT_ZERO;
            end else begin
               state_s = ST_ARMED;
            end
         end
         ST_ACTIVE: begin
            if (frame_start) begin
               err_s      = 1'b1;
               pix_cnt_s  = CNT_ZERO;
               skin_acc_s = CNT_ZERO;
            end else if (face_flag) begin
               if (pix_cnt_r == LAST_PIX) begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else begin
                  pix_cnt_s  = pix_cnt_r + CNT_ONE;
                  skin_acc_s = skin_total_s;
               end
            end else begin
               state_s = ST_ACTIVE;
            end
         end
         ST_DONE: begin
            if (enable_s) state_s = ST_ARMED;
            else          state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         pix_cnt_r    <= CNT_ZERO;
         skin_acc_r   <= CNT_ZERO;
         skin_cnt_r   <= CNT_ZERO;
         det_en_r     <= 1'b0;
         frame_done_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         pix_cnt_r    <= pix_cnt_s;
         skin_acc_r   <= skin_acc_s;
         det_en_r     <= (state_s == ST_ACTIVE);
         frame_done_r <= done_s;
         frame_err_r  <= err_s;
         if (done_s) begin
            skin_cnt_r <= skin_total_s;
         end
      end
   end

   assign det_en     = det_en_r;
   assign frame_done = frame_done_r;
   assign frame_err  = frame_err_r;
   assign skin_cnt   = skin_cnt_r;

endmodule

// File: tb/tb_face_det_ctrl.sv
// Scoreboard bench for face_det_ctrl: a behavioural model queues expected acks,
// frame results and frame errors; a negedge monitor pops and compares them.
module tb_face_det_ctrl;
   import face_pkg::*;

   localparam int PPF   = 16;
   localparam int CNT_W = 5;

   logic             sclk = 1'b0;
   logic             rst_n = 1'b0;
   logic             frame_start = 1'b0;
   logic             face_flag = 1'b0;
   logic [7:0]       face_data = 8'd0;
   logic [7:0]       cb_lower, cb_upper, cr_lower, cr_upper;
   logic             det_en, frame_done, frame_err;
   logic [CNT_W-1:0] skin_cnt;

   face_det_ctrl_if cfg_bus();

   face_det_ctrl #(.PIX_PER_FRAME(PPF), .CNT_W(CNT_W)) dut (
      .sclk(sclk), .rst_n(rst_n), .cfg(cfg_bus),
      .frame_start(frame_start), .face_flag(face_flag), .face_data(face_data),
      .cb_lower(cb_lower), .cb_upper(cb_upper), .cr_lower(cr_lower), .cr_upper(cr_upper),
      .det_en(det_en), .frame_done(frame_done), .skin_cnt(skin_cnt), .frame_err(frame_err)
   );

   always #5 sclk = ~sclk;

   int cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: registers, frame phase (0 idle, 1 armed, 2 active) and counts
   logic [7:0] m_sh [4];
   logic [7:0] m_act [4];
   bit         m_pend, m_err, m_en;
   int         m_phase, m_beats, m_skin;

   typedef struct { int c; int s; } done_t;
   done_t done_q [$];
   int    ack_q [$];
   int    err_q [$];
   done_t mon_d;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic fail_evt(input string name);
      n_checks++;
      $display("FAIL %s: event with no expectation queued (cycle %0d)", name, cyc);
   endtask

   // monitor: every DUT event must match the head of its expectation queue
   always @(negedge sclk) begin
      if (rst_n) begin
         if (cfg_bus.cfg_ack) begin
            if (ack_q.size() == 0) fail_evt("cfg_ack");
            else chk("cfg_ack cycle", cyc, ack_q.pop_front());
         end
         if (frame_done) begin
            if (done_q.size() == 0) fail_evt("frame_done");
            else begin
               mon_d = done_q.pop_front();
               chk("frame_done cycle", cyc, mon_d.c);
               chk("skin_cnt", int'(skin_cnt), mon_d.s);
            end
         end
         if (frame_err) begin
            if (err_q.size() == 0) fail_evt("frame_err");
            else chk("frame_err cycle", cyc, err_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic model_reset();
      m_sh[0] = 8'd77;  m_sh[1] = 8'd127; m_sh[2] = 8'd133; m_sh[3] = 8'd173;
      m_act = m_sh;
      m_pend = 1'b0; m_err = 1'b0; m_en = 1'b0;
      m_phase = 0; m_beats = 0; m_skin = 0;
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
      cfg_bus.cfg_wr = 1'b1;
      cfg_bus.cfg_addr = a;
      cfg_bus.cfg_wdata = d;
      ack_q.push_back(cyc + 1);
      if (a < 3'd4) begin
         m_sh[a[1:0]] = d;
      end else if (a == 3'd4) begin
         m_en = d[0];
         if (d[1]) begin
            if (m_sh[0] < m_sh[1] && m_sh[2] < m_sh[3]) begin
               m_pend = 1'b1;
               m_err  = 1'b0;
            end else begin
               m_err = 1'b1;
            end
         end
         if (m_en && m_phase == 0) m_phase = 1;
         if (!m_en && m_phase == 1) m_phase = 0;
      end
      tick();
      cfg_bus.cfg_wr = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      if (m_pend) begin
         m_act = m_sh;
         m_pend = 1'b0;
      end
      if (m_phase == 1) begin
         m_phase = 2; m_beats = 0; m_skin = 0;
      end else if (m_phase == 2) begin
         err_q.push_back(cyc + 1);
         m_beats = 0; m_skin = 0;
      end
      tick();
      frame_start = 1'b0;
   endtask

   task automatic send_beat(input bit skin);
      face_flag = 1'b1;
      face_data = skin ? 8'd255 : 8'($urandom_range(0, 127));
      if (m_phase == 2) begin
         m_beats++;
         m_skin += int'(skin);
         if (m_beats == PPF) begin
            done_q.push_back('{cyc + 1, m_skin});
            m_phase = m_en ? 1 : 0;
         end
      end
      tick();
      face_flag = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
   endtask

   task automatic rand_beats(input int n);
      for (int i = 0; i < n; i++) send_beat(1'($urandom_range(0, 1)));
   endtask

   task automatic check_thr(input string tag);
      chk({tag, " cb_lower"}, int'(cb_lower), int'(m_act[0]));
      chk({tag, " cb_upper"}, int'(cb_upper), int'(m_act[1]));
      chk({tag, " cr_lower"}, int'(cr_lower), int'(m_act[2]));
      chk({tag, " cr_upper"}, int'(cr_upper), int'(m_act[3]));
      chk({tag, " cfg_err"}, int'(cfg_bus.cfg_err), int'(m_err));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_thr(tag);
      chk({tag, " det_en"}, int'(det_en), 0);
      chk({tag, " skin_cnt"}, int'(skin_cnt), 0);
      chk({tag, " frame_done"}, int'(frame_done), 0);
      chk({tag, " frame_err"}, int'(frame_err), 0);
      chk({tag, " cfg_ack"}, int'(cfg_bus.cfg_ack), 0);
   endtask

   initial begin
      cfg_bus.cfg_wr = 1'b0;
      cfg_bus.cfg_addr = 3'd0;
      cfg_bus.cfg_wdata = 8'd0;
      model_reset();
      idle(3);
      rst_n = 1'b1;
      idle(1);
      check_reset_outputs("reset");

      // first frame: exactly 5 skin beats, beats before frame_start ignored
      cfg_write(3'd4, 8'h01);
      idle(2);
      chk("armed det_en", int'(det_en), 0);
      for (int i = 0; i < 3; i++) send_beat(1'b1);
      pulse_fs();
      chk("active det_en", int'(det_en), 1);
      for (int i = 0; i < PPF; i++) send_beat((i % 3 == 0) && (i < 15));
      idle(2);
      chk("post-frame det_en", int'(det_en), 0);

      // commit mid-frame applies only at the next frame_start
      pulse_fs();
      rand_beats(4);
      cfg_write(3'd0, 8'd90);
      cfg_write(3'd4, 8'h03);
      check_thr("mid-frame commit");
      rand_beats(PPF - 4);
      idle(2);
      pulse_fs();
      check_thr("after commit");
      rand_beats(PPF);
      idle(2);

      // rejected commit, then a valid one clears cfg_err
      cfg_write(3'd0, 8'd130);
      cfg_write(3'd4, 8'h03);
      check_thr("bad commit");
      pulse_fs();
      check_thr("bad commit frame");
      rand_beats(PPF);
      idle(2);
      cfg_write(3'd0, 8'd80);
      cfg_write(3'd4, 8'h03);
      check_thr("good commit");
      pulse_fs();
      check_thr("good commit frame");
      rand_beats(PPF);
      idle(2);

      // early frame_start aborts the frame and restarts counting
      pulse_fs();
      rand_beats(7);
      pulse_fs();
      rand_beats(PPF);
      idle(2);

      // randomized shadow writes and commits
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 2; j++)
            cfg_write(3'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         cfg_write(3'd4, {6'd0, 1'($urandom_range(0, 1)), 1'b1});
         pulse_fs();
         check_thr("random frame");
         rand_beats(PPF);
         idle(2);
      end

      // disable during a frame: frame completes, then stays idle
      pulse_fs();
      rand_beats(5);
      cfg_write(3'd4, 8'h00);
      rand_beats(PPF - 5);
      idle(2);
      chk("disabled det_en", int'(det_en), 0);
      pulse_fs();
      idle(2);
      chk("idle ignores frame_start", int'(det_en), 0);

      // async reset mid-frame
      cfg_write(3'd4, 8'h01);
      idle(2);
      pulse_fs();
      rand_beats(10);
      rst_n = 1'b0;
      #1;
      model_reset();
      ack_q.delete();
      check_reset_outputs("async reset");
      idle(2);
      rst_n = 1'b1;
      idle(1);
      cfg_write(3'd4, 8'h01);
      idle(2);
      pulse_fs();
      chk("re-enabled det_en", int'(det_en), 1);
      rand_beats(PPF);
      idle(3);

      chk("pending acks", ack_q.size(), 0);
      chk("pending frame_done", done_q.size(), 0);
      chk("pending frame_err", err_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
